// File: rtl/router_sync_nport_if.sv
// Handshake bundle between the router FSM/FIFO side and router_sync_nport.
// Optional status signals exist only when ROUTER_SYNC_STATUS_EN is defined.
interface router_sync_nport_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 detect_add;
    logic [ADDR_W-1:0]    data_in;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;
`ifdef ROUTER_SYNC_STATUS_EN
    logic [NUM_PORTS-1:0] timeout_sts;
    logic                 sts_clr;

    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb, sts_clr,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_sts
    );
    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb, sts_clr,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_sts
    );
`else
    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err
    );
    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err
    );
`endif
endinterface

// File: rtl/router_sync_nport.sv
// N-port router write/read synchroniser: address latch, write steering, per-port watchdog.
// Optional sticky timeout status is enabled by defining ROUTER_SYNC_STATUS_EN.
module router_sync_nport #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    router_sync_nport_if.slave    bus
);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    // One extra bit so NUM_PORTS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]             soft_reset_q, soft_reset_d;
    logic [NUM_PORTS-1:0]             sel_s;
    logic [NUM_PORTS-1:0]             write_enb_s;
    logic                             fifo_full_s;
    logic                             addr_err_s;

    function automatic logic [NUM_PORTS-1:0] port_decode(input logic [ADDR_W-1:0] addr);
        logic [NUM_PORTS-1:0] dec;
        dec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dec[i] = (addr == ADDR_W'(i));
        end
        return dec;
    endfunction

    // Destination address capture on header detection.
    always_comb begin
        addr_d = addr_q;
        if (bus.detect_add) begin
            addr_d = bus.data_in;
        end else begin
            addr_d = addr_q;
        end
    end

    // Write steering and full-flag return; an illegal address drops the packet.
    always_comb begin
        addr_err_s  = ({1'b0, addr_q} >= PORT_LIMIT);
        sel_s       = port_decode(addr_q);
        write_enb_s = '0;
        fifo_full_s = 1'b0;
        if (!resetn || addr_err_s) begin
            write_enb_s = '0;
            fifo_full_s = 1'b0;
        end else begin
            write_enb_s = bus.write_enb_reg ? sel_s : '0;
            fifo_full_s = |(bus.full & sel_s);
        end
    end

    // Per-port stall counters; the counter clears on the timeout instead of wrapping.
    always_comb begin
        cnt_d        = cnt_q;
        soft_reset_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.empty[i] || bus.read_enb[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]        = '0;
                soft_reset_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            soft_reset_q <= '0;
        end else begin
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    assign bus.write_enb  = write_enb_s;
    assign bus.fifo_full  = fifo_full_s;
    assign bus.vld_out    = ~bus.empty;
    assign bus.soft_reset = soft_reset_q;
    assign bus.addr_err   = addr_err_s;

`ifdef ROUTER_SYNC_STATUS_EN
    logic [NUM_PORTS-1:0] timeout_sts_q, timeout_sts_d;

    // Sticky timeout status; a pulse arriving with a clear request keeps the bit set.
    always_comb begin
        timeout_sts_d = timeout_sts_q;
        if (bus.sts_clr) begin
            timeout_sts_d = soft_reset_q;
        end else begin
            timeout_sts_d = timeout_sts_q | soft_reset_q;
        end
    end

    // Status register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timeout_sts_q <= '0;
        end else begin
            timeout_sts_q <= timeout_sts_d;
        end
    end

    assign bus.timeout_sts = timeout_sts_q;
`endif

endmodule

// File: tb/tb_router_sync_nport.sv
// Directed self-checking bench for router_sync_nport (NUM_PORTS=3, TIMEOUT=30).
// Status checks are included when ROUTER_SYNC_STATUS_EN is defined.
module tb_router_sync_nport;

    logic clock;
    logic resetn;
    int   checks;
    int   failures;
    logic [2:0] exp3;

    router_sync_nport_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

    router_sync_nport #(
        .NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(5)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.detect_add = 1'b0; bus.data_in = 2'd0; bus.write_enb_reg = 1'b1;
        bus.full = 3'b111; bus.empty = 3'b111; bus.read_enb = 3'b000;
`ifdef ROUTER_SYNC_STATUS_EN
        bus.sts_clr = 1'b0;
`endif
        tick(); tick();
        checks++; if (bus.write_enb !== 3'b000) begin failures++; $display("FAIL reset_write_enb actual=%b required=000", bus.write_enb); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL reset_fifo_full actual=%b required=0", bus.fifo_full); end
        checks++; if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL reset_soft_reset actual=%b required=000", bus.soft_reset); end
        checks++; if (bus.vld_out !== 3'b000) begin failures++; $display("FAIL reset_vld_out actual=%b required=000", bus.vld_out); end
        checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err actual=%b required=0", bus.addr_err); end
        resetn = 1'b1;
        #1;
        checks++; if (bus.write_enb !== 3'b001) begin failures++; $display("FAIL reset_release_addr0 actual=%b required=001", bus.write_enb); end
        bus.write_enb_reg = 1'b0; bus.full = 3'b000;
        tick();
    endtask

    task automatic test_steering();
        bus.detect_add = 1'b1; bus.data_in = 2'd2;
        #1;
        checks++; if (bus.write_enb !== 3'b000) begin failures++; $display("FAIL steer_idle actual=%b required=000", bus.write_enb); end
        tick();
        bus.detect_add = 1'b0; bus.data_in = 2'd1; bus.write_enb_reg = 1'b1; bus.full = 3'b100;
        #1;
        checks++; if (bus.write_enb !== 3'b100) begin failures++; $display("FAIL steer_we2 actual=%b required=100", bus.write_enb); end
        checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL steer_full2 actual=%b required=1", bus.fifo_full); end
        tick();
        checks++; if (bus.write_enb !== 3'b100) begin failures++; $display("FAIL steer_hold actual=%b required=100", bus.write_enb); end
        bus.detect_add = 1'b1; bus.data_in = 2'd1;
        #1;
        checks++; if (bus.write_enb !== 3'b100) begin failures++; $display("FAIL steer_not_yet actual=%b required=100", bus.write_enb); end
        tick();
        bus.detect_add = 1'b0;
        #1;
        checks++; if (bus.write_enb !== 3'b010) begin failures++; $display("FAIL steer_we1 actual=%b required=010", bus.write_enb); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL steer_full1 actual=%b required=0", bus.fifo_full); end
        bus.full = 3'b010;
        #1;
        checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL steer_full1_set actual=%b required=1", bus.fifo_full); end
        bus.write_enb_reg = 1'b0;
        #1;
        checks++; if (bus.write_enb !== 3'b000) begin failures++; $display("FAIL steer_no_wr actual=%b required=000", bus.write_enb); end
        bus.full = 3'b000;
    endtask

    task automatic test_vld();
        bus.empty = 3'b010; #1;
        checks++; if (bus.vld_out !== 3'b101) begin failures++; $display("FAIL vld_a actual=%b required=101", bus.vld_out); end
        bus.empty = 3'b100; #1;
        checks++; if (bus.vld_out !== 3'b011) begin failures++; $display("FAIL vld_b actual=%b required=011", bus.vld_out); end
        bus.empty = 3'b111; #1;
        checks++; if (bus.vld_out !== 3'b000) begin failures++; $display("FAIL vld_c actual=%b required=000", bus.vld_out); end
        tick();
    endtask

    task automatic test_bad_addr();
        bus.detect_add = 1'b1; bus.data_in = 2'd3;
        tick();
        bus.detect_add = 1'b0; bus.write_enb_reg = 1'b1; bus.full = 3'b111;
        #1;
        checks++; if (bus.addr_err !== 1'b1) begin failures++; $display("FAIL bad_addr_err actual=%b required=1", bus.addr_err); end
        checks++; if (bus.write_enb !== 3'b000) begin failures++; $display("FAIL bad_addr_we actual=%b required=000", bus.write_enb); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL bad_addr_full actual=%b required=0", bus.fifo_full); end
        bus.detect_add = 1'b1; bus.data_in = 2'd0;
        tick();
        bus.detect_add = 1'b0;
        #1;
        checks++; if (bus.addr_err !== 1'b0) begin failures++; $display("FAIL good_addr_err actual=%b required=0", bus.addr_err); end
        checks++; if (bus.write_enb !== 3'b001) begin failures++; $display("FAIL good_addr_we actual=%b required=001", bus.write_enb); end
        bus.write_enb_reg = 1'b0; bus.full = 3'b000;
    endtask

    task automatic test_timeout();
        bus.empty = 3'b101; bus.read_enb = 3'b000;
        for (int k = 1; k <= 61; k++) begin
            tick();
            exp3 = (k == 30 || k == 60) ? 3'b010 : 3'b000;
            checks++;
            if (bus.soft_reset !== exp3) begin failures++; $display("FAIL timeout_cycle%0d actual=%b required=%b", k, bus.soft_reset, exp3); end
        end
        bus.empty = 3'b111;
        tick();
    endtask

    task automatic test_rescue();
        bus.empty = 3'b110; bus.read_enb = 3'b000;
        for (int k = 1; k <= 29; k++) begin
            tick();
            checks++;
            if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL rescue_pre%0d actual=%b required=000", k, bus.soft_reset); end
        end
        bus.read_enb = 3'b001;
        tick();
        checks++; if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL rescue_read actual=%b required=000", bus.soft_reset); end
        bus.read_enb = 3'b000;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp3 = (k == 30) ? 3'b001 : 3'b000;
            checks++;
            if (bus.soft_reset !== exp3) begin failures++; $display("FAIL rescue_post%0d actual=%b required=%b", k, bus.soft_reset, exp3); end
        end
        bus.empty = 3'b111;
        tick();
    endtask

    task automatic test_concurrent();
        bus.empty = 3'b000; bus.read_enb = 3'b000;
        for (int k = 1; k <= 31; k++) begin
            tick();
            exp3 = (k == 30) ? 3'b111 : 3'b000;
            checks++;
            if (bus.soft_reset !== exp3) begin failures++; $display("FAIL concurrent%0d actual=%b required=%b", k, bus.soft_reset, exp3); end
        end
        bus.empty = 3'b111;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.empty = 3'b011; bus.read_enb = 3'b000;
        repeat (20) tick();
        resetn = 1'b0;
        tick();
        checks++; if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL midrst_edge actual=%b required=000", bus.soft_reset); end
        resetn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp3 = (k == 30) ? 3'b100 : 3'b000;
            checks++;
            if (bus.soft_reset !== exp3) begin failures++; $display("FAIL midrst_post%0d actual=%b required=%b", k, bus.soft_reset, exp3); end
        end
        repeat (29) tick();
        resetn = 1'b0;
        tick();
        checks++; if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL midrst_pending actual=%b required=000", bus.soft_reset); end
        resetn = 1'b1;
        tick();
        checks++; if (bus.soft_reset !== 3'b000) begin failures++; $display("FAIL midrst_after actual=%b required=000", bus.soft_reset); end
        bus.empty = 3'b111;
        tick();
    endtask

`ifdef ROUTER_SYNC_STATUS_EN
    task automatic test_status();
        bus.empty = 3'b101; bus.read_enb = 3'b000; bus.sts_clr = 1'b0;
        repeat (30) tick();
        checks++; if (bus.soft_reset !== 3'b010) begin failures++; $display("FAIL sts_pulse1 actual=%b required=010", bus.soft_reset); end
        checks++; if (bus.timeout_sts !== 3'b000) begin failures++; $display("FAIL sts_before actual=%b required=000", bus.timeout_sts); end
        tick();
        checks++; if (bus.timeout_sts !== 3'b010) begin failures++; $display("FAIL sts_set actual=%b required=010", bus.timeout_sts); end
        bus.sts_clr = 1'b1;
        tick();
        checks++; if (bus.timeout_sts !== 3'b000) begin failures++; $display("FAIL sts_clr actual=%b required=000", bus.timeout_sts); end
        bus.sts_clr = 1'b0;
        repeat (28) tick();
        checks++; if (bus.soft_reset !== 3'b010) begin failures++; $display("FAIL sts_pulse2 actual=%b required=010", bus.soft_reset); end
        bus.sts_clr = 1'b1;
        tick();
        checks++; if (bus.timeout_sts !== 3'b010) begin failures++; $display("FAIL sts_set_wins actual=%b required=010", bus.timeout_sts); end
        bus.sts_clr = 1'b0;
        resetn = 1'b0;
        tick();
        checks++; if (bus.timeout_sts !== 3'b000) begin failures++; $display("FAIL sts_reset actual=%b required=000", bus.timeout_sts); end
        resetn = 1'b1;
        bus.empty = 3'b111;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_steering();
        test_vld();
        test_bad_addr();
        test_timeout();
        test_rescue();
        test_concurrent();
        test_mid_reset();
`ifdef ROUTER_SYNC_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
